// File: rtl/onewire_alarm_ctrl_pkg.sv
// Shared constants for the 1-wire alarm-check sequencer: FSM encodings,
// counter width and the sign-bit position of sign-magnitude temperatures.
package onewire_alarm_ctrl_pkg;

    localparam int OW_DATA_W   = 8;
    localparam int OW_SIGN_BIT = 7;
    localparam int OW_CNT_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CMP_HI = 2'd1,
        ST_CMP_LO = 2'd2,
        ST_UPDATE = 2'd3
    } ow_state_e;

endpackage

// File: rtl/onewire_alarm_ctrl_comparator.sv
// Combinational 8-bit sign-magnitude comparator: a_ge_b_o = (a_i >= b_i).
// Negative zero (0x80) orders strictly below positive zero (0x00).
module onewire_comparator
    import onewire_alarm_ctrl_pkg::*;
(
    input  logic [OW_DATA_W-1:0] a_i,
    input  logic [OW_DATA_W-1:0] b_i,
    output logic                 a_ge_b_o
);

    logic                     a_neg;
    logic                     b_neg;
    logic [OW_SIGN_BIT-1:0]   a_mag;
    logic [OW_SIGN_BIT-1:0]   b_mag;

    assign a_neg = a_i[OW_SIGN_BIT];
    assign b_neg = b_i[OW_SIGN_BIT];
    assign a_mag = a_i[OW_SIGN_BIT-1:0];
    assign b_mag = b_i[OW_SIGN_BIT-1:0];

    always_comb begin
        a_ge_b_o = 1'b0;
        if (a_neg != b_neg) begin
            a_ge_b_o = ~a_neg;
        end else if (!a_neg) begin
            a_ge_b_o = (a_mag >= b_mag);
        end else begin
            // both negative: the smaller magnitude is the larger value
            a_ge_b_o = (a_mag <= b_mag);
        end
    end

endmodule

// File: rtl/onewire_alarm_ctrl.sv
// Alarm-check sequencer run after each temperature conversion; debounces
// temp>=TH / TL>=temp into alarm_flag. Optional ONEWIRE_ALARM_DIR_EN adds alarm_hi/alarm_lo.
module onewire_alarm_ctrl
    import onewire_alarm_ctrl_pkg::*;
#(
    parameter int ALARM_CNT = 1,
    parameter int CNT_W     = OW_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 conv_done,
    input  logic [OW_DATA_W-1:0] temp,
    input  logic [OW_DATA_W-1:0] th,
    input  logic [OW_DATA_W-1:0] tl,
    input  logic                 alarm_clr,
    output logic                 busy,
    output logic                 done,
    output logic                 alarm_flag,
    output logic                 overrun
`ifdef ONEWIRE_ALARM_DIR_EN
    ,
    output logic                 alarm_hi,
    output logic                 alarm_lo
`endif
);

    localparam logic [CNT_W:0] ALARM_CNT_L = (CNT_W+1)'(ALARM_CNT);

    ow_state_e              state_q, state_d;
    logic [OW_DATA_W-1:0]   t_q, th_q, tl_q;
    logic [OW_DATA_W-1:0]   cmp_a, cmp_b;
    logic                   cmp_ge;
    logic                   hi_q, lo_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   busy_q, done_q, flag_q, overrun_q;
    logic                   alarm;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
    endfunction

    function automatic logic cnt_hit(input logic [CNT_W-1:0] c);
        return ({1'b0, c} + (CNT_W+1)'(1)) >= ALARM_CNT_L;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (conv_done) state_d = ST_CMP_HI;
            ST_CMP_HI: state_d = ST_CMP_LO;
            ST_CMP_LO: state_d = ST_UPDATE;
            ST_UPDATE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // One comparator shared by both checks; held on t/th when idle to avoid toggling.
    always_comb begin
        cmp_a = t_q;
        cmp_b = th_q;
        if (state_q == ST_CMP_LO) begin
            cmp_a = tl_q;
            cmp_b = t_q;
        end
    end

    onewire_comparator u_cmp (
        .a_i      (cmp_a),
        .b_i      (cmp_b),
        .a_ge_b_o (cmp_ge)
    );

    assign alarm = hi_q | lo_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            t_q       <= '0;
            th_q      <= '0;
            tl_q      <= '0;
            hi_q      <= 1'b0;
            lo_q      <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            flag_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            busy_q <= (state_d != ST_IDLE);
            done_q <= 1'b0;
            if (state_q == ST_IDLE && conv_done) begin
                t_q  <= temp;
                th_q <= th;
                tl_q <= tl;
            end
            if (state_q != ST_IDLE && conv_done) begin
                overrun_q <= 1'b1;
            end
            if (state_q == ST_CMP_HI) hi_q <= cmp_ge;
            if (state_q == ST_CMP_LO) lo_q <= cmp_ge;
            if (state_q == ST_UPDATE) begin
                done_q <= 1'b1;
                if (alarm) begin
                    cnt_q <= sat_inc(cnt_q);
                    if (cnt_hit(cnt_q)) flag_q <= 1'b1;
                end else begin
                    cnt_q  <= '0;
                    flag_q <= 1'b0;
                end
            end
            // clear overrides any update or overrun event in the same cycle
            if (alarm_clr) begin
                cnt_q     <= '0;
                flag_q    <= 1'b0;
                overrun_q <= 1'b0;
            end
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign alarm_flag = flag_q;
    assign overrun    = overrun_q;

`ifdef ONEWIRE_ALARM_DIR_EN
    logic [1:0] dir_cond;
    logic [1:0] dir_flag;

    assign dir_cond = {lo_q, hi_q};

    // Channel 0 debounces the high condition, channel 1 the low condition.
    for (genvar gi = 0; gi < 2; gi++) begin : g_dir
        logic [CNT_W-1:0] dcnt_q;
        logic             dflag_q;

        always_ff @(posedge clk) begin
            if (rst || alarm_clr) begin
                dcnt_q  <= '0;
                dflag_q <= 1'b0;
            end else if (state_q == ST_UPDATE) begin
                if (dir_cond[gi]) begin
                    dcnt_q <= sat_inc(dcnt_q);
                    if (cnt_hit(dcnt_q)) dflag_q <= 1'b1;
                end else begin
                    dcnt_q  <= '0;
                    dflag_q <= 1'b0;
                end
            end
        end

        assign dir_flag[gi] = dflag_q;
    end

    assign alarm_hi = dir_flag[0];
    assign alarm_lo = dir_flag[1];
`endif

endmodule

// File: tb/tb_onewire_alarm_ctrl.sv
// Directed bench for onewire_alarm_ctrl: one instance with ALARM_CNT=1, one with ALARM_CNT=3.
module tb_onewire_alarm_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       conv_done;
    logic       alarm_clr;
    logic [7:0] temp, th, tl;
    logic       busy, done, alarm_flag, overrun;
    logic       busy3, done3, flag3, ovr3;
`ifdef ONEWIRE_ALARM_DIR_EN
    logic       ahi, alo, ahi3, alo3;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    onewire_alarm_ctrl #(.ALARM_CNT(1)) dut (
        .clk(clk), .rst(rst), .conv_done(conv_done), .temp(temp), .th(th), .tl(tl),
        .alarm_clr(alarm_clr), .busy(busy), .done(done), .alarm_flag(alarm_flag),
        .overrun(overrun)
`ifdef ONEWIRE_ALARM_DIR_EN
        , .alarm_hi(ahi), .alarm_lo(alo)
`endif
    );

    onewire_alarm_ctrl #(.ALARM_CNT(3)) dut3 (
        .clk(clk), .rst(rst), .conv_done(conv_done), .temp(temp), .th(th), .tl(tl),
        .alarm_clr(alarm_clr), .busy(busy3), .done(done3), .alarm_flag(flag3),
        .overrun(ovr3)
`ifdef ONEWIRE_ALARM_DIR_EN
        , .alarm_hi(ahi3), .alarm_lo(alo3)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        alarm_clr = 1'b1;
        tick();
        alarm_clr = 1'b0;
    endtask

    // Pulse conv_done with temperature t and wait (bounded) for done.
    task automatic run_conv(input logic [7:0] t, output logic got, output int lat,
                            output int bcnt, output logic busy_at_done);
        conv_done = 1'b1;
        temp = t;
        got = 1'b0;
        lat = 0;
        bcnt = 0;
        busy_at_done = 1'b1;
        for (int i = 0; i < 12 && !got; i++) begin
            tick();
            conv_done = 1'b0;
            lat++;
            if (done) begin
                got = 1'b1;
                busy_at_done = busy;
            end else if (busy) begin
                bcnt++;
            end
        end
        $display("conv temp=%02h th=%02h tl=%02h done=%0b lat=%0d flag=%0b flag3=%0b ovr=%0b",
                 t, th, tl, got, lat, alarm_flag, flag3, overrun);
    endtask

    task automatic test_reset();
        rst = 1'b1; conv_done = 1'b0; alarm_clr = 1'b0;
        temp = 8'h00; th = 8'h19; tl = 8'h05;
        tick(); tick();
        rst = 1'b0;
        checks++;
        if ({busy, done, alarm_flag, overrun, busy3, done3, flag3, ovr3} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs got=%08b exp=00000000",
                     {busy, done, alarm_flag, overrun, busy3, done3, flag3, ovr3});
        end
        $display("reset done");
    endtask

    task automatic test_basic();
        logic got, bad;
        int lat, bcnt;
        th = 8'h19; tl = 8'h05;
        run_conv(8'h1A, got, lat, bcnt, bad);
        checks++;
        if (got !== 1'b1) begin errors++; $display("FAIL basic_done got=%0b exp=1", got); end
        checks++;
        if (lat != 4) begin errors++; $display("FAIL basic_latency got=%0d exp=4", lat); end
        checks++;
        if (bcnt != 3) begin errors++; $display("FAIL basic_busy_cycles got=%0d exp=3", bcnt); end
        checks++;
        if (bad !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got=%0b exp=0", bad); end
        checks++;
        if (alarm_flag !== 1'b1) begin errors++; $display("FAIL basic_flag got=%0b exp=1", alarm_flag); end
        checks++;
        if (flag3 !== 1'b0) begin errors++; $display("FAIL basic_flag_cnt3 got=%0b exp=0", flag3); end
        tick();
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL basic_done_width got=%0b exp=0", done); end
    endtask

    logic [7:0] v_th   [11] = '{8'h19, 8'h19, 8'h19, 8'h19, 8'h19, 8'h19, 8'h19, 8'h85, 8'h85, 8'h85, 8'h19};
    logic [7:0] v_tl   [11] = '{8'h05, 8'h05, 8'h00, 8'h80, 8'h05, 8'h05, 8'h05, 8'h8A, 8'h8A, 8'h8A, 8'h05};
    logic [7:0] v_temp [11] = '{8'h10, 8'h85, 8'h80, 8'h00, 8'h19, 8'h05, 8'h06, 8'h87, 8'h8A, 8'h84, 8'hFF};
    logic       v_exp  [11] = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1,  1'b1};

    task automatic test_compare();
        logic got, bad;
        int lat, bcnt;
        for (int i = 0; i < 11; i++) begin
            th = v_th[i];
            tl = v_tl[i];
            run_conv(v_temp[i], got, lat, bcnt, bad);
            checks++;
            if (got !== 1'b1 || alarm_flag !== v_exp[i]) begin
                errors++;
                $display("FAIL compare_%0d temp=%02h done=%0b flag=%0b exp_flag=%0b",
                         i, v_temp[i], got, alarm_flag, v_exp[i]);
            end
        end
    endtask

    logic [7:0] d_temp [7] = '{8'h1A, 8'h1A, 8'h1A, 8'h10, 8'h1A, 8'h1A, 8'h1A};
    logic       d_exp  [7] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b1};

    task automatic test_debounce();
        logic got, bad;
        int lat, bcnt;
        th = 8'h19; tl = 8'h05;
        pulse_clr();
        for (int i = 0; i < 7; i++) begin
            run_conv(d_temp[i], got, lat, bcnt, bad);
            checks++;
            if (got !== 1'b1 || flag3 !== d_exp[i]) begin
                errors++;
                $display("FAIL debounce_%0d temp=%02h done=%0b flag3=%0b exp_flag3=%0b",
                         i, d_temp[i], got, flag3, d_exp[i]);
            end
        end
    endtask

    task automatic test_overrun();
        logic got, bad;
        int lat, bcnt;
        th = 8'h19; tl = 8'h05;
        pulse_clr();
        conv_done = 1'b1; temp = 8'h10;
        tick();
        temp = 8'h1A;
        tick();
        conv_done = 1'b0;
        checks++;
        if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set got=%0b exp=1", overrun); end
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            if (done) got = 1'b1; else tick();
        end
        $display("overrun conv done=%0b flag=%0b ovr=%0b", got, alarm_flag, overrun);
        checks++;
        if (got !== 1'b1 || alarm_flag !== 1'b0) begin
            errors++;
            $display("FAIL overrun_first_only done=%0b flag=%0b exp_flag=0", got, alarm_flag);
        end
        run_conv(8'h1A, got, lat, bcnt, bad);
        checks++;
        if (overrun !== 1'b1 || alarm_flag !== 1'b1) begin
            errors++;
            $display("FAIL overrun_sticky ovr=%0b flag=%0b exp=1/1", overrun, alarm_flag);
        end
        pulse_clr();
        checks++;
        if (overrun !== 1'b0 || alarm_flag !== 1'b0) begin
            errors++;
            $display("FAIL clr_effect ovr=%0b flag=%0b exp=0/0", overrun, alarm_flag);
        end
    endtask

    task automatic test_clr_at_update();
        th = 8'h19; tl = 8'h05;
        conv_done = 1'b1; temp = 8'h1A;
        tick();
        conv_done = 1'b0;
        tick(); tick();
        // now in UPDATE: clear and a stray conv_done arrive together
        alarm_clr = 1'b1; conv_done = 1'b1;
        tick();
        alarm_clr = 1'b0; conv_done = 1'b0;
        $display("clr@update done=%0b flag=%0b ovr=%0b", done, alarm_flag, overrun);
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL clr_update_done got=%0b exp=1", done); end
        checks++;
        if (alarm_flag !== 1'b0) begin errors++; $display("FAIL clr_update_flag got=%0b exp=0", alarm_flag); end
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL clr_overrun got=%0b exp=0", overrun); end
        tick();
    endtask

    task automatic test_reset_mid();
        logic got, bad, seen;
        int lat, bcnt;
        th = 8'h19; tl = 8'h05;
        run_conv(8'h1A, got, lat, bcnt, bad);
        conv_done = 1'b1; temp = 8'h1A;
        tick();
        conv_done = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({busy, done, alarm_flag, overrun} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid_outputs got=%04b exp=0000", {busy, done, alarm_flag, overrun});
        end
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (done) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL reset_mid_no_done got=%0b exp=0", seen); end
        run_conv(8'h1A, got, lat, bcnt, bad);
        checks++;
        if (got !== 1'b1 || lat != 4 || alarm_flag !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_resume done=%0b lat=%0d flag=%0b exp=1/4/1", got, lat, alarm_flag);
        end
    endtask

`ifdef ONEWIRE_ALARM_DIR_EN
    task automatic test_dir();
        logic got, bad;
        int lat, bcnt;
        th = 8'h19; tl = 8'h05;
        run_conv(8'h1A, got, lat, bcnt, bad);
        checks++;
        if ({ahi, alo} !== 2'b10) begin errors++; $display("FAIL dir_high got=%02b exp=10", {ahi, alo}); end
        run_conv(8'h83, got, lat, bcnt, bad);
        checks++;
        if ({ahi, alo} !== 2'b01) begin errors++; $display("FAIL dir_low got=%02b exp=01", {ahi, alo}); end
        pulse_clr();
        checks++;
        if ({ahi, alo} !== 2'b00) begin errors++; $display("FAIL dir_clr got=%02b exp=00", {ahi, alo}); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_compare();
        test_debounce();
        test_overrun();
        test_clr_at_update();
        test_reset_mid();
`ifdef ONEWIRE_ALARM_DIR_EN
        test_dir();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
